// File: rtl/seg7_capture.sv
// Samples an asynchronous 7-segment bus, debounces it and decodes accepted glyphs back to hex digits.
// Optional sequence checker (expects each digit = previous + 1 mod 16) enabled by SEG7_CAPTURE_SEQCHK_EN.
module seg7_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       digit_stb,
    output logic       blank,
    output logic       bad_stb,
    output logic       seq_err_stb,
    output logic [7:0] seq_err_cnt
);

    typedef enum logic {SETTLING, LOCKED} state_t;

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    logic [6:0] sync_q [SYNC_STAGES];
    logic [6:0] s;
    logic [6:0] s_prev;
    logic [6:0] last_pat;
    logic [3:0] cnt;
    state_t     state;
    logic       accept;
    logic [4:0] dec;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h3F:   r = {1'b1, 4'h0};
            7'h06:   r = {1'b1, 4'h1};
            7'h5B:   r = {1'b1, 4'h2};
            7'h4F:   r = {1'b1, 4'h3};
            7'h66:   r = {1'b1, 4'h4};
            7'h6D:   r = {1'b1, 4'h5};
            7'h7D:   r = {1'b1, 4'h6};
            7'h07:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h6F:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h7C:   r = {1'b1, 4'hB};
            7'h39:   r = {1'b1, 4'hC};
            7'h5E:   r = {1'b1, 4'hD};
            7'h79:   r = {1'b1, 4'hE};
            7'h71:   r = {1'b1, 4'hF};
            default: r = 5'b0;
        endcase
        return r;
    endfunction

    assign s   = sync_q[SYNC_STAGES-1];
    assign dec = decode(s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 7'h00;
        end else begin
            sync_q[0] <= seg_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // Accept fires on the edge where the counter reaches STABLE_CYCLES, and only for a new pattern.
    assign accept = (s == s_prev) && (state == SETTLING) && (cnt == CNT_LAST) && (s != last_pat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= 7'h00;
            cnt    <= 4'd0;
            state  <= SETTLING;
        end else begin
            s_prev <= s;
            if (s != s_prev) begin
                cnt   <= 4'd1;
                state <= SETTLING;
            end else if (state == SETTLING) begin
                cnt <= cnt + 4'd1;
                if (cnt == CNT_LAST) state <= LOCKED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pat    <= 7'h00;
            digit       <= 4'h0;
            digit_valid <= 1'b0;
            digit_stb   <= 1'b0;
            blank       <= 1'b0;
            bad_stb     <= 1'b0;
        end else begin
            digit_stb <= 1'b0;
            bad_stb   <= 1'b0;
            if (accept) begin
                last_pat <= s;
                if (dec[4]) begin
                    digit       <= dec[3:0];
                    digit_valid <= 1'b1;
                    blank       <= 1'b0;
                    digit_stb   <= 1'b1;
                end else if (s == 7'h00) begin
                    digit_valid <= 1'b0;
                    blank       <= 1'b1;
                end else begin
                    digit_valid <= 1'b0;
                    blank       <= 1'b0;
                    bad_stb     <= 1'b1;
                end
            end
        end
    end

`ifdef SEG7_CAPTURE_SEQCHK_EN
    logic       have_prev;
    logic [3:0] prev_digit;

    // Blank or illegal patterns break the chain, so the following digit is not checked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_prev   <= 1'b0;
            prev_digit  <= 4'h0;
            seq_err_stb <= 1'b0;
            seq_err_cnt <= 8'd0;
        end else begin
            seq_err_stb <= 1'b0;
            if (accept) begin
                if (dec[4]) begin
                    have_prev  <= 1'b1;
                    prev_digit <= dec[3:0];
                    if (have_prev && (dec[3:0] != prev_digit + 4'd1)) begin
                        seq_err_stb <= 1'b1;
                        if (seq_err_cnt != 8'hFF) seq_err_cnt <= seq_err_cnt + 8'd1;
                    end
                end else begin
                    have_prev <= 1'b0;
                end
            end
        end
    end
`else
    assign seq_err_stb = 1'b0;
    assign seq_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: run-length reference model predicts accepts, monitor checks strobes.
module tb_seg7_capture;

    localparam int STABLE = 4;
    localparam int SYNC   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] seg_in = 7'h3F;
    logic [3:0] digit;
    logic       digit_valid, digit_stb, blank, bad_stb, seq_err_stb;
    logic [7:0] seq_err_cnt;

    seg7_capture #(.STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .seg_in(seg_in),
        .digit(digit), .digit_valid(digit_valid), .digit_stb(digit_stb),
        .blank(blank), .bad_stb(bad_stb), .seq_err_stb(seq_err_stb),
        .seq_err_cnt(seq_err_cnt)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int         cyc;
        logic       dstb;
        logic       bad;
        logic [3:0] digit;
        logic       dv;
        logic       blank;
        logic       serr;
        logic [7:0] ecnt;
    } exp_t;

    exp_t q[$];
    exp_t e, ev;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: a value seen on STABLE consecutive samples is accepted once, if it is new.
    logic [6:0] m_last, run_val;
    int         run_len, m_idx, m_prev, m_err;
    logic [3:0] m_digit;
    bit         m_have;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_last = 7'h00; run_val = 7'h00; run_len = 0;
            m_digit = 4'h0; m_have = 0; m_prev = 0; m_err = 0;
        end else begin
            if (seg_in === run_val) begin
                if (run_len < 1000) run_len++;
            end else begin
                run_val = seg_in;
                run_len = 1;
            end
            if (run_len == STABLE && run_val != m_last) begin
                m_last = run_val;
                m_idx = -1;
                for (int k = 0; k < 16; k++) if (glyph[k] == run_val) m_idx = k;
                e.cyc = cyc + SYNC;
                e.dstb = 0; e.bad = 0; e.serr = 0;
                if (m_idx >= 0) begin
                    e.dstb = 1; e.dv = 1; e.blank = 0;
                    m_digit = 4'(m_idx);
`ifdef SEG7_CAPTURE_SEQCHK_EN
                    if (m_have && m_idx != (m_prev + 1) % 16) begin
                        e.serr = 1;
                        if (m_err < 255) m_err++;
                    end
                    m_have = 1;
                    m_prev = m_idx;
`endif
                end else if (run_val == 7'h00) begin
                    e.dv = 0; e.blank = 1;
                    m_have = 0;
                end else begin
                    e.bad = 1; e.dv = 0; e.blank = 0;
                    m_have = 0;
                end
                e.digit = m_digit;
                e.ecnt = 8'(m_err);
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {digit, digit_valid, digit_stb, blank, bad_stb, seq_err_stb, seq_err_cnt}, 0);
            q.delete();
        end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++;
                $display("FAIL event_missed: due cycle %0d, none by cycle %0d", q[0].cyc, cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                ev = q.pop_front();
                chk("digit_stb", digit_stb, ev.dstb);
                chk("bad_stb", bad_stb, ev.bad);
                chk("digit", digit, ev.digit);
                chk("digit_valid", digit_valid, ev.dv);
                chk("blank", blank, ev.blank);
                chk("seq_err_stb", seq_err_stb, ev.serr);
                chk("seq_err_cnt", seq_err_cnt, ev.ecnt);
            end else begin
                chk("stray_strobe", {digit_stb, bad_stb, seq_err_stb}, 0);
            end
        end
    end

    task automatic hold(input logic [6:0] v, input int n);
        seg_in = v;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    int r;

    initial begin
        #1 rst_n = 1'b0;
        seg_in = 7'h3F;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        // Count 0..F then wrap to 0
        hold(7'h3F, 20);
        for (int d = 1; d < 16; d++) hold(glyph[d], 20);
        hold(7'h3F, 20);

        // Glitch and return to the same glyph
        hold(7'h06, 20);
        hold(7'h4F, 2);
        hold(7'h06, 20);

        // Skip 3 -> sequence error
        hold(7'h5B, 20);
        hold(7'h66, 20);

        // Blank, illegal, then a digit that must not be checked
        hold(7'h00, 20);
        hold(7'h01, 20);
        hold(7'h3F, 20);

        // Reset in the middle of settling
        hold(7'h06, 3);
        rst_n = 1'b0;
        hold(7'h06, 3);
        rst_n = 1'b1;
        hold(7'h06, 20);

        // 300 consecutive sequence errors
        for (int i = 0; i < 300; i++) hold((i % 2) ? 7'h5B : 7'h3F, 6);
        @(negedge clk);
`ifdef SEG7_CAPTURE_SEQCHK_EN
        chk("seq_err_cnt_saturated", seq_err_cnt, 8'd255);
`else
        chk("seq_err_cnt_tied", seq_err_cnt, 8'd0);
`endif
        @(posedge clk);
        #2;

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 6)       seg_in = glyph[$urandom_range(0, 15)];
            else if (r == 6) seg_in = 7'h00;
            else if (r == 7) seg_in = 7'($urandom_range(0, 127));
            hold(seg_in, $urandom_range(1, 10));
        end
        hold(7'h7F, 20);

        for (int i = 0; i < 40 && q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout: %0d expected events outstanding, required 0", q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
